// File: rtl/conv_core_feeder.sv
// conv_core_feeder: loads K weight/input columns into the convolution core, then
// sums the core's K*K sign-magnitude cell products into one signed window result.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both
// high. col_valid/w_col/x_col are held by the sequencer until accepted.
// acc_valid/acc_out are held by this block until acc_ready is seen high.
module conv_core_feeder #(
   parameter int N          = 16,
   parameter int S          = 2,
   parameter int K          = 3,
   parameter int ACC_W      = 24,
   parameter int SETTLE_CYC = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 col_valid,
   output logic                 col_ready,
   input  logic [N*K-1:0]       w_col,
   input  logic [N*S*K-1:0]     x_col,
   output logic [N*K-1:0]       weights,
   output logic [N*S*K-1:0]     input_layer,
   output logic                 weight_buffer_en,
   output logic                 input_buffer_en,
   output logic                 weight_en,
   output logic                 input_en,
   input  logic [N-1:0]         product_result,
   input  logic                 one_cell_done,
   input  logic                 one_conv_done,
   output logic [ACC_W-1:0]     acc_out,
   output logic                 acc_valid,
   input  logic                 acc_ready,
   output logic                 busy,
   output logic                 err
);

   localparam int BEAT_W = $clog2(K + 1);
   localparam int PROD_W = $clog2(K * K + 1);
   localparam int SET_W  = $clog2(SETTLE_CYC + 2);
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(K - 1);
   localparam logic [PROD_W-1:0] PROD_LAST = PROD_W'(K * K);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SETTLE  = 3'd2,
      COMPUTE = 3'd3,
      OUT     = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [BEAT_W-1:0] beat_cnt;
   logic [SET_W-1:0]  settle_cnt;
   logic [PROD_W-1:0] prod_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic [ACC_W-1:0]  acc;
   logic              cell_prev;
   logic              conv_prev;

   logic              handshake;
   logic              cell_event;
   logic              conv_event;
   logic [PROD_W-1:0] prod_inc;
   logic              prod_full;
   logic              wd_expire;
   logic [ACC_W-1:0]  mag;
   logic [ACC_W-1:0]  acc_sum;

   logic col_ready_nx;
   logic buf_en_nx;
   logic busy_nx;
   logic acc_valid_nx;
   logic err_nx;

   // Events are rising edges only, and only count while computing.
   assign handshake  = (state == LOAD) && col_valid && col_ready;
   assign cell_event = (state == COMPUTE) && one_cell_done && !cell_prev;
   assign conv_event = (state == COMPUTE) && one_conv_done && !conv_prev;
   assign prod_inc   = prod_cnt + {{(PROD_W-1){1'b0}}, cell_event};
   assign prod_full  = (prod_inc == PROD_LAST);
   assign wd_expire  = !cell_event && (wd_cnt == WD_LAST);

   // Sign-magnitude to two's complement: magnitude zero-extended, sign picks add/sub.
   assign mag     = {{(ACC_W-N+1){1'b0}}, product_result[N-2:0]};
   assign acc_sum = product_result[N-1] ? (acc - mag) : (acc + mag);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; a full product count wins over a same-cycle conv_done.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (col_valid) state_nx = LOAD;
         LOAD:    if (handshake && (beat_cnt == BEAT_LAST)) state_nx = SETTLE;
         SETTLE:  if (settle_cnt == SET_LAST) state_nx = COMPUTE;
         COMPUTE: begin
            if (prod_full)                    state_nx = OUT;
            else if (conv_event || wd_expire) state_nx = IDLE;
         end
         OUT:     if (acc_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered control outputs, derived from the transition.
   always_comb begin
      col_ready_nx = (state_nx == LOAD);
      // Enables stay high through the first SETTLE cycle, which carries the last strobe.
      buf_en_nx    = (state_nx == LOAD) || ((state == LOAD) && (state_nx == SETTLE));
      busy_nx      = (state_nx != IDLE);
      acc_valid_nx = (state_nx == OUT);
      // Leaving COMPUTE for IDLE only happens on early conv_done or watchdog expiry.
      err_nx       = err || ((state == COMPUTE) && (state_nx == IDLE));
   end

   // Registered outputs toward the core and downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_ready        <= 1'b0;
         weight_buffer_en <= 1'b0;
         input_buffer_en  <= 1'b0;
         weight_en        <= 1'b0;
         input_en         <= 1'b0;
         weights          <= '0;
         input_layer      <= '0;
         acc_out          <= '0;
         acc_valid        <= 1'b0;
         busy             <= 1'b0;
         err              <= 1'b0;
      end else begin
         col_ready        <= col_ready_nx;
         weight_buffer_en <= buf_en_nx;
         input_buffer_en  <= buf_en_nx;
         weight_en        <= handshake;
         input_en         <= handshake;
         acc_valid        <= acc_valid_nx;
         busy             <= busy_nx;
         err              <= err_nx;
         if (handshake) begin
            weights     <= w_col;
            input_layer <= x_col;
         end
         if ((state == COMPUTE) && (state_nx == OUT)) acc_out <= acc_sum;
      end
   end

   // Counters, watchdog, accumulator and edge-detect history.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt   <= '0;
         settle_cnt <= '0;
         prod_cnt   <= '0;
         wd_cnt     <= '0;
         acc        <= '0;
         cell_prev  <= 1'b0;
         conv_prev  <= 1'b0;
      end else begin
         cell_prev <= one_cell_done;
         conv_prev <= one_conv_done;

         if (state != LOAD)  beat_cnt <= '0;
         else if (handshake) beat_cnt <= beat_cnt + 1'b1;

         if (state != SETTLE) settle_cnt <= '0;
         else                 settle_cnt <= settle_cnt + 1'b1;

         if (state != COMPUTE) prod_cnt <= '0;
         else                  prod_cnt <= prod_inc;

         if ((state != COMPUTE) || cell_event) wd_cnt <= '0;
         else                                   wd_cnt <= wd_cnt + 1'b1;

         // Any return to IDLE (result taken, error) discards the sum.
         if (state_nx == IDLE) acc <= '0;
         else if (cell_event)  acc <= acc_sum;
      end
   end

endmodule

// File: doc/conv_core_feeder.md
Name: conv_core_feeder

Overview:
- Drives the load interface of the K x K convolution core: column-by-column weight and input buffer fills using buffer-enable and column strobes.
- Then consumes the core's K*K sign-magnitude per-cell products and accumulates them into one signed two's-complement result.
- Sits between the layer sequencer, which supplies paired weight/input columns over valid/ready, and the convolution core.
- Presents one accumulated value per convolution window over valid/ready.

Parameters:
- N, 16, word width; core product_result is sign bit N-1 plus magnitude [N-2:0]
- S, 2, stride; an input column carries S*K words
- K, 3, kernel size; K column beats per load, K*K products per window
- ACC_W, 24, accumulator width; must be >= N + clog2(K*K)
- SETTLE_CYC, 2, cycles both buffer enables stay low before products are monitored
- TIMEOUT, 1024, maximum cycles allowed between successive product events in COMPUTE

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- col_valid  in  1  upstream column pair valid
- col_ready  out  1  column pair accepted when col_valid && col_ready
- w_col  in  N*K  weight column
- x_col  in  N*S*K  input column
- weights  out  N*K  to core; registered
- input_layer  out  N*S*K  to core; registered
- weight_buffer_en  out  1  to core; high for the whole weight fill
- input_buffer_en  out  1  to core; high for the whole input fill
- weight_en  out  1  to core; one-cycle column strobe
- input_en  out  1  to core; one-cycle column strobe
- product_result  in  N  from core; sign-magnitude product
- one_cell_done  in  1  from core; level, product valid while high
- one_conv_done  in  1  from core; window complete
- acc_out  out  ACC_W  signed window sum
- acc_valid  out  1  acc_out valid; held until accepted
- acc_ready  in  1  downstream accept
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol/timeout error; cleared only by rst

Behaviour:
- All outputs are registered. On reset: every output is 0, state is IDLE, accumulator, counters and edge-detect registers are 0. Reset mid-operation drops both enables and both strobes on the same edge and discards the partial sum.
- States: IDLE, LOAD, SETTLE, COMPUTE, OUT.
- IDLE: col_ready=0. If col_valid=1, go to LOAD; buffer enables go high on that edge.
- LOAD:
  - Both buffer enables are high and col_ready=1.
  - Each handshake registers w_col->weights and x_col->input_layer and asserts weight_en and input_en for exactly the next cycle.
  - Back-to-back handshakes give consecutive strobes.
  - beat_cnt counts 0..K-1. On the K-th handshake, col_ready drops on the next edge and the state goes to SETTLE.
- SETTLE:
  - The first SETTLE cycle keeps both buffer enables high while carrying the final strobe.
  - The enables then go low and stay low for SETTLE_CYC cycles, after which the state goes to COMPUTE.
  - The watchdog and the product counter clear on entry to COMPUTE.
- COMPUTE:
  - A product event is a rising edge of one_cell_done (current high, registered previous low).
  - On each event, product_result is sampled in that same cycle. The magnitude is zero-extended to ACC_W and added to acc if the sign bit is 0, subtracted if it is 1.
  - Negative zero adds 0.
  - prod_cnt increments and the watchdog clears.
  - When prod_cnt reaches K*K, go to OUT with acc_valid=1 on the next edge.
- one_conv_done rising in COMPUTE before K*K events (the event in the same cycle counts): set err, return to IDLE, no acc_valid.
- Watchdog reaches TIMEOUT with no event: set err, return to IDLE.
- OUT: acc_out and acc_valid are held stable until acc_ready=1. On handshake: acc_valid=0, acc cleared, state IDLE. col_ready stays 0 throughout OUT, so no new load overlaps an unconsumed result.
- Product events outside COMPUTE are ignored.
- one_conv_done outside COMPUTE is ignored.
- Accumulation wraps modulo 2^ACC_W; the ACC_W parameter rule guarantees no overflow for legal inputs.

Test Plan:
- Load and accumulate (N=16, K=3, S=2): col_valid held high with 3 pairs -> weight_en/input_en high 3 consecutive cycles, each carrying its column; buffer enables fall one cycle after the last strobe. Core model then gives nine products 0x0064 -> acc_out=900, acc_valid until acc_ready.
- Mixed signs: eight products 0x0005 and one 0x8014 -> acc_out=20. All nine products 0x8001 -> acc_out=-9 (0xFFFFF7). Negative-zero product 0x8000 -> no contribution.
- Backpressure: acc_ready low for 10 cycles after acc_valid -> acc_out stable, col_ready=0, col_valid ignored. acc_ready=1 -> IDLE next cycle.
- Early conv_done: one_conv_done rises after 4 product events -> err=1, state IDLE, acc_valid never asserts; err stays 1 through later windows until rst.
- Timeout (TIMEOUT=64): no one_cell_done edge after COMPUTE entry -> err=1 and IDLE exactly 64 cycles later. Held-high one_cell_done counts as one event only.
- Reset mid-LOAD after 2 beats -> next cycle all enables/strobes 0, busy=0. A following full window produces a correct sum with no stale contribution.
